mem_arbiter: RTL and testbench

- Shares one pipelined, multi-cycle main memory between three requesters: I-cache miss fills, D-cache miss fills and D-side write-through stores.
- Sits between the split cache front-ends (IF and MEM stages) and the unified memory.
- Sequences each cache miss as a full block fill and returns the words with a word index, so each cache writes its own data array.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/fill_counter.sv | 44 ++++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant types and geometry defaults for the memory arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF      = 16;
    localparam int DATA_W_DEF      = 16;
    localparam int BLOCK_WORDS_DEF = 8;
    localparam int MEM_LAT_DEF     = 4;
    localparam int WORD_IDX_W      = $clog2(BLOCK_WORDS_DEF);
    localparam int BLK_OFF_W       = WORD_IDX_W + 1;

    typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_e;

    typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_D, GNT_I} grant_e;

    // D side belongs to the older instruction, so it outranks the I side
    function automatic grant_e arb_pick(input logic wr, input logic dm, input logic im);
        return wr ? GNT_WR : dm ? GNT_D : im ? GNT_I : GNT_NONE;
    endfunction

endpackage

// File: rtl/fill_counter.sv
// fill_counter: issue/receive counters and read addressing for one block fill
module fill_counter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WIW    = WORD_IDX_W,
    parameter int OFW    = BLK_OFF_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                active,
    input  logic [ADDR_W-1:OFW] blk_addr,
    input  logic                rvalid,
    output logic                issue,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [WIW-1:0]      word,
    output logic                last
);

    logic [WIW:0]   ic;
    logic [WIW-1:0] rc;

    // ic's top bit marks "all reads issued"; aligned blocks make base + 2*ic a plain concat
    always_comb begin
        issue   = active && !ic[WIW];
        rd_addr = {blk_addr, ic[WIW-1:0], 1'b0};
        word    = rc;
        last    = active && rvalid && &rc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic <= '0;
            rc <= '0;
        end else if (!active || last) begin
            ic <= '0;
            rc <= '0;
        end else begin
            if (issue) ic <= ic + (WIW + 1)'(1);
            if (rvalid) rc <= rc + WIW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory between I-fill, D-fill and D-store requesters
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int MEM_LAT     = MEM_LAT_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_miss_req,
    input  logic [ADDR_W-1:0]              i_miss_addr,
    output logic                           i_fill_valid,
    output logic [DATA_W-1:0]              i_fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] i_fill_word,
    output logic                           i_fill_done,
    input  logic                           d_miss_req,
    input  logic [ADDR_W-1:0]              d_miss_addr,
    output logic                           d_fill_valid,
    output logic [DATA_W-1:0]              d_fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] d_fill_word,
    output logic                           d_fill_done,
    input  logic                           d_wr_req,
    input  logic [ADDR_W-1:0]              d_wr_addr,
    input  logic [DATA_W-1:0]              d_wr_data,
    output logic                           d_wr_ack,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    input  logic                           mem_rvalid,
    output logic                           busy
);

    localparam int WIW = $clog2(BLOCK_WORDS);

    if (MEM_LAT < 1 || BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_param_check
        $error("mem_arbiter: MEM_LAT must be >= 1 and BLOCK_WORDS a power of 2 >= 2");
    end

    state_e            state;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              fill, issue, last, wr_cyc, i_rx, d_rx;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIW-1:0]    word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_addr <= '0;
            lat_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    case (arb_pick(d_wr_req, d_miss_req, i_miss_req))
                        GNT_WR: begin
                            state    <= WRITE;
                            lat_addr <= d_wr_addr;
                            lat_data <= d_wr_data;
                        end
                        GNT_D: begin
                            state    <= FILL_D;
                            lat_addr <= d_miss_addr;
                        end
                        GNT_I: begin
                            state    <= FILL_I;
                            lat_addr <= i_miss_addr;
                        end
                        default: state <= IDLE;
                    endcase
                end
                WRITE:   state <= IDLE;
                default: if (last) state <= IDLE;
            endcase
        end
    end

    fill_counter #(
        .ADDR_W (ADDR_W),
        .WIW    (WIW),
        .OFW    (WIW + 1)
    ) u_fill (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (fill),
        .blk_addr (lat_addr[ADDR_W-1:WIW+1]),
        .rvalid   (mem_rvalid),
        .issue    (issue),
        .rd_addr  (rd_addr),
        .word     (word),
        .last     (last)
    );

    // read data is gated by fill state so stray rvalids in IDLE never reach a cache
    always_comb begin
        wr_cyc       = state == WRITE;
        fill         = state == FILL_I || state == FILL_D;
        i_rx         = state == FILL_I && mem_rvalid;
        d_rx         = state == FILL_D && mem_rvalid;
        mem_en       = wr_cyc || issue;
        mem_wr       = wr_cyc;
        mem_addr     = wr_cyc ? lat_addr : issue ? rd_addr : '0;
        mem_wdata    = wr_cyc ? lat_data : '0;
        d_wr_ack     = wr_cyc;
        i_fill_valid = i_rx;
        i_fill_data  = i_rx ? mem_rdata : '0;
        i_fill_word  = i_rx ? word : '0;
        i_fill_done  = state == FILL_I && last;
        d_fill_valid = d_rx;
        d_fill_data  = d_rx ? mem_rdata : '0;
        d_fill_word  = d_rx ? word : '0;
        d_fill_done  = state == FILL_D && last;
        busy         = state != IDLE;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a fixed-latency memory model
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_miss_req, d_miss_req, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        i_fill_valid, i_fill_done, d_fill_valid, d_fill_done, d_wr_ack;
    logic [15:0] i_fill_data, d_fill_data;
    logic [2:0]  i_fill_word, d_fill_word;
    logic        mem_en, mem_wr, mem_rvalid, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        stray = 1'b0;
    logic [77:0] all_out;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } mem_exp_t;

    typedef struct {
        logic [2:0]  word;
        logic [15:0] data;
        logic        done;
        int          cyc;
    } fill_exp_t;

    mem_exp_t  q_mem[$];
    fill_exp_t q_i[$];
    fill_exp_t q_d[$];
    int        cyc = 0, errors = 0, checks = 0;

    mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_miss_req   (i_miss_req),
        .i_miss_addr  (i_miss_addr),
        .i_fill_valid (i_fill_valid),
        .i_fill_data  (i_fill_data),
        .i_fill_word  (i_fill_word),
        .i_fill_done  (i_fill_done),
        .d_miss_req   (d_miss_req),
        .d_miss_addr  (d_miss_addr),
        .d_fill_valid (d_fill_valid),
        .d_fill_data  (d_fill_data),
        .d_fill_word  (d_fill_word),
        .d_fill_done  (d_fill_done),
        .d_wr_req     (d_wr_req),
        .d_wr_addr    (d_wr_addr),
        .d_wr_data    (d_wr_data),
        .d_wr_ack     (d_wr_ack),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .busy         (busy)
    );

    assign all_out = {i_fill_valid, i_fill_data, i_fill_word, i_fill_done,
                      d_fill_valid, d_fill_data, d_fill_word, d_fill_done,
                      d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, busy};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // memory contents are a fixed function of the word address
    function automatic logic [15:0] pat(input logic [15:0] a);
        return (a * 16'd37) ^ 16'h5A3C;
    endfunction

    logic [MEM_LAT-1:0] pv = '0;
    logic [15:0]        pd [MEM_LAT];

    always @(posedge clk) begin
        pv    <= {pv[MEM_LAT-2:0], mem_en && !mem_wr};
        pd[0] <= pat(mem_addr);
        for (int i = 1; i < MEM_LAT; i++) pd[i] <= pd[i-1];
    end

    assign mem_rvalid = pv[MEM_LAT-1] | stray;
    assign mem_rdata  = stray ? 16'hDEAD : pd[MEM_LAT-1];

    // scoreboard: every memory access and every returned word is popped and compared
    always @(negedge clk) begin
        mem_exp_t  me;
        fill_exp_t fe;
        if (mem_en) begin
            checks++;
            if (q_mem.size() == 0) begin
                errors++;
                $display("FAIL mem_op: unexpected wr=%0b addr=%h at cycle %0d, required no access", mem_wr, mem_addr, cyc);
            end else begin
                me = q_mem.pop_front();
                if (mem_wr !== me.wr || mem_addr !== me.addr || mem_wdata !== (me.wr ? me.data : 16'h0) ||
                    d_wr_ack !== me.wr || cyc != me.cyc) begin
                    errors++;
                    $display("FAIL mem_op: got wr=%0b addr=%h wdata=%h ack=%0b cyc=%0d, required wr=%0b addr=%h wdata=%h ack=%0b cyc=%0d",
                             mem_wr, mem_addr, mem_wdata, d_wr_ack, cyc, me.wr, me.addr, me.wr ? me.data : 16'h0, me.wr, me.cyc);
                end
            end
        end
        if (i_fill_valid || i_fill_done) begin
            checks++;
            if (q_i.size() == 0) begin
                errors++;
                $display("FAIL i_fill: unexpected valid=%0b word=%0d data=%h at cycle %0d, required none", i_fill_valid, i_fill_word, i_fill_data, cyc);
            end else begin
                fe = q_i.pop_front();
                if (!i_fill_valid || i_fill_word !== fe.word || i_fill_data !== fe.data || i_fill_done !== fe.done || cyc != fe.cyc) begin
                    errors++;
                    $display("FAIL i_fill: got valid=%0b word=%0d data=%h done=%0b cyc=%0d, required valid=1 word=%0d data=%h done=%0b cyc=%0d",
                             i_fill_valid, i_fill_word, i_fill_data, i_fill_done, cyc, fe.word, fe.data, fe.done, fe.cyc);
                end
            end
        end
        if (d_fill_valid || d_fill_done) begin
            checks++;
            if (q_d.size() == 0) begin
                errors++;
                $display("FAIL d_fill: unexpected valid=%0b word=%0d data=%h at cycle %0d, required none", d_fill_valid, d_fill_word, d_fill_data, cyc);
            end else begin
                fe = q_d.pop_front();
                if (!d_fill_valid || d_fill_word !== fe.word || d_fill_data !== fe.data || d_fill_done !== fe.done || cyc != fe.cyc) begin
                    errors++;
                    $display("FAIL d_fill: got valid=%0b word=%0d data=%h done=%0b cyc=%0d, required valid=1 word=%0d data=%h done=%0b cyc=%0d",
                             d_fill_valid, d_fill_word, d_fill_data, d_fill_done, cyc, fe.word, fe.data, fe.done, fe.cyc);
                end
            end
        end
    end

    // queue the 8 reads starting at cycle t and the words returning MEM_LAT later
    function automatic void exp_fill(input bit is_d, input logic [15:0] addr, input int t);
        mem_exp_t    me;
        fill_exp_t   fe;
        logic [15:0] a;
        for (int k = 0; k < 8; k++) begin
            a  = (addr & 16'hFFF0) + 16'(2 * k);
            me = '{1'b0, a, 16'h0, t + k};
            fe = '{3'(k), pat(a), k == 7, t + MEM_LAT + k};
            q_mem.push_back(me);
            if (is_d) q_d.push_back(fe);
            else q_i.push_back(fe);
        end
    endfunction

    function automatic void exp_write(input logic [15:0] addr, input logic [15:0] data, input int t);
        mem_exp_t me;
        me = '{1'b1, addr, data, t};
        q_mem.push_back(me);
    endfunction

    task automatic wait_for(input int which, output int when);
        when = -1;
        for (int k = 0; k < 80; k++) begin
            if ((which == 0 && i_fill_done) || (which == 1 && d_fill_done) || (which == 2 && d_wr_ack)) begin
                when = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (q_mem.size() + q_i.size() + q_d.size()) != 0; k++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL idle_outputs: got %h, required 0", all_out);
        end
    endtask

    task automatic test_i_miss();
        int t, when;
        t = cyc;
        exp_fill(1'b0, 16'h0136, t + 1);
        i_miss_addr = 16'h0136;
        i_miss_req  = 1'b1;
        wait_for(0, when);
        i_miss_req = 1'b0;
        checks++;
        if (when != t + 12) begin
            errors++;
            $display("FAIL i_miss_done_cycle: got %0d, required %0d", when, t + 12);
        end
        drain();
        checks++;
        if (q_mem.size() + q_i.size() + q_d.size() != 0) begin
            errors++;
            $display("FAIL i_miss_pending: got %0d outstanding, required 0", q_mem.size() + q_i.size() + q_d.size());
        end
    endtask

    task automatic test_priority();
        int t, when;
        t = cyc;
        exp_write(16'h2000, 16'hBEEF, t + 1);
        exp_fill(1'b1, 16'h3008, t + 3);
        exp_fill(1'b0, 16'h0010, t + 16);
        d_wr_addr   = 16'h2000;
        d_wr_data   = 16'hBEEF;
        d_miss_addr = 16'h3008;
        i_miss_addr = 16'h0010;
        {d_wr_req, d_miss_req, i_miss_req} = 3'b111;
        wait_for(2, when);
        d_wr_req = 1'b0;
        checks++;
        if (when != t + 1) begin
            errors++;
            $display("FAIL prio_ack_cycle: got %0d, required %0d", when, t + 1);
        end
        wait_for(1, when);
        d_miss_req = 1'b0;
        checks++;
        if (when != t + 14) begin
            errors++;
            $display("FAIL prio_d_done_cycle: got %0d, required %0d", when, t + 14);
        end
        wait_for(0, when);
        i_miss_req = 1'b0;
        checks++;
        if (when != t + 27) begin
            errors++;
            $display("FAIL prio_i_done_cycle: got %0d, required %0d", when, t + 27);
        end
        drain();
        checks++;
        if (q_mem.size() + q_i.size() + q_d.size() != 0) begin
            errors++;
            $display("FAIL prio_pending: got %0d outstanding, required 0", q_mem.size() + q_i.size() + q_d.size());
        end
    endtask

    task automatic test_write_mid_fill();
        int t, when;
        t = cyc;
        exp_fill(1'b0, 16'h0500, t + 1);
        i_miss_addr = 16'h0500;
        i_miss_req  = 1'b1;
        repeat (4) @(negedge clk);
        exp_write(16'h0600, 16'h1234, t + 14);
        d_wr_addr = 16'h0600;
        d_wr_data = 16'h1234;
        d_wr_req  = 1'b1;
        wait_for(0, when);
        i_miss_req = 1'b0;
        checks++;
        if (when != t + 12) begin
            errors++;
            $display("FAIL midwr_i_done_cycle: got %0d, required %0d", when, t + 12);
        end
        wait_for(2, when);
        d_wr_req = 1'b0;
        checks++;
        if (when != t + 14) begin
            errors++;
            $display("FAIL midwr_ack_cycle: got %0d, required %0d", when, t + 14);
        end
        drain();
        checks++;
        if (q_mem.size() + q_i.size() + q_d.size() != 0) begin
            errors++;
            $display("FAIL midwr_pending: got %0d outstanding, required 0", q_mem.size() + q_i.size() + q_d.size());
        end
    endtask

    task automatic test_wrap();
        int t, when;
        t = cyc;
        exp_fill(1'b0, 16'hFFFE, t + 1);
        i_miss_addr = 16'hFFFE;
        i_miss_req  = 1'b1;
        wait_for(0, when);
        i_miss_req = 1'b0;
        checks++;
        if (when != t + 12) begin
            errors++;
            $display("FAIL wrap_done_cycle: got %0d, required %0d", when, t + 12);
        end
        drain();
        checks++;
        if (q_mem.size() + q_i.size() + q_d.size() != 0) begin
            errors++;
            $display("FAIL wrap_pending: got %0d outstanding, required 0", q_mem.size() + q_i.size() + q_d.size());
        end
    endtask

    task automatic test_reset_mid_fill();
        int        t, when;
        mem_exp_t  me;
        fill_exp_t fe;
        t = cyc;
        for (int k = 0; k < 5; k++) begin
            me = '{1'b0, 16'h3100 + 16'(2 * k), 16'h0, t + 1 + k};
            q_mem.push_back(me);
        end
        fe = '{3'd0, pat(16'h3100), 1'b0, t + 5};
        q_d.push_back(fe);
        d_miss_addr = 16'h3106;
        d_miss_req  = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        d_miss_req = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h, required 0", all_out);
        end
        checks++;
        if (q_mem.size() + q_d.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_pre: got %0d outstanding before reset, required 0", q_mem.size() + q_d.size());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            stray = 1'b1;
            #1;
            checks++;
            if ({i_fill_valid, d_fill_valid} !== 2'b00) begin
                errors++;
                $display("FAIL stray_rvalid: got fill_valid i=%0b d=%0b, required 0 0", i_fill_valid, d_fill_valid);
            end
            @(negedge clk);
        end
        stray = 1'b0;
        repeat (6) @(negedge clk);
        t = cyc;
        exp_fill(1'b1, 16'h3106, t + 1);
        d_miss_req = 1'b1;
        wait_for(1, when);
        d_miss_req = 1'b0;
        checks++;
        if (when != t + 12) begin
            errors++;
            $display("FAIL rst_refill_done_cycle: got %0d, required %0d", when, t + 12);
        end
        drain();
        checks++;
        if (q_mem.size() + q_i.size() + q_d.size() != 0) begin
            errors++;
            $display("FAIL rst_refill_pending: got %0d outstanding, required 0", q_mem.size() + q_i.size() + q_d.size());
        end
    endtask

    task automatic test_back_to_back();
        int t, low, low_at, d1, d2;
        t      = cyc;
        low    = 0;
        low_at = -1;
        d1     = -1;
        d2     = -1;
        exp_fill(1'b0, 16'h0A00, t + 1);
        exp_fill(1'b0, 16'h0A00, t + 14);
        i_miss_addr = 16'h0A00;
        i_miss_req  = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (!busy) begin
                low++;
                low_at = cyc;
            end
            if (i_fill_done) begin
                if (d1 < 0) d1 = cyc;
                else d2 = cyc;
            end
            if (cyc == t + 14) i_miss_req = 1'b0;
        end
        i_miss_req = 1'b0;
        checks++;
        if (low != 1 || low_at != t + 13) begin
            errors++;
            $display("FAIL b2b_busy_gap: got %0d idle cycles last at %0d, required 1 at %0d", low, low_at, t + 13);
        end
        checks++;
        if (d1 != t + 12 || d2 != t + 25) begin
            errors++;
            $display("FAIL b2b_done_cycles: got %0d/%0d, required %0d/%0d", d1, d2, t + 12, t + 25);
        end
        drain();
        checks++;
        if (q_mem.size() + q_i.size() + q_d.size() != 0) begin
            errors++;
            $display("FAIL b2b_pending: got %0d outstanding, required 0", q_mem.size() + q_i.size() + q_d.size());
        end
    endtask

    initial begin
        {i_miss_req, d_miss_req, d_wr_req} = 3'b000;
        {i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data} = '0;
        test_reset();
        test_i_miss();
        test_priority();
        test_write_mid_fill();
        test_wrap();
        test_reset_mid_fill();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
